multicycle_compare: RTL and testbench

//   Multi-cycle magnitude/equality comparator for branch resolution. Walks two

---
 rtl/multicycle_compare.sv | 144 ++++++++++++++
 tb/tb_multicycle_compare.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/multicycle_compare.sv
// ============================================================================
// Module   : multicycle_compare
// Purpose  : Digit-serial (2 bits/cycle, MSB first) magnitude/equality
//            comparator for branch resolution, signed or unsigned.
// Option   : CMP_EARLY_EXIT_EN - finish as soon as the order is decided.
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module multicycle_compare #(
  parameter int WIDTH  = 32,
  parameter int SIGNED = 1
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] opA,
  input  logic [WIDTH-1:0] opB,
  output logic             ready,
  output logic             busy,
  output logic             done,
  output logic             eq,
  output logic             gt,
  output logic             lt
);

  localparam int N    = WIDTH / 2;
  localparam int IDXW = (N > 1) ? $clog2(N) : 1;

  // Flipping the sign bit maps two's-complement order onto unsigned order.
  localparam logic [WIDTH-1:0] c_sign_mask =
    (SIGNED != 0) ? {1'b1, {(WIDTH-1){1'b0}}} : {WIDTH{1'b0}};
  localparam logic [IDXW-1:0] c_idx_first = IDXW'(N - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           r_state;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [IDXW-1:0]  r_idx;
  logic             r_eq_acc;
  logic             r_gt_acc;
  logic             r_ready;
  logic             r_busy;
  logic             r_done;
  logic             r_eq;
  logic             r_gt;
  logic             r_lt;

  logic [1:0]       w_a_dig;
  logic [1:0]       w_b_dig;
  logic             w_accept;
  logic             w_eq_next;
  logic             w_gt_next;
  logic             w_last;
  logic             w_finish;

  // Operands shift left each step, so the current digit is always the top pair.
  assign w_a_dig   = r_a[WIDTH-1 -: 2];
  assign w_b_dig   = r_b[WIDTH-1 -: 2];
  assign w_accept  = start && r_ready;
  assign w_eq_next = r_eq_acc ? (w_a_dig == w_b_dig) : 1'b0;
  assign w_gt_next = r_eq_acc ? (w_a_dig >  w_b_dig) : r_gt_acc;
  assign w_last    = (r_idx == '0);

`ifdef CMP_EARLY_EXIT_EN
  assign w_finish  = w_last || !w_eq_next;
`else
  assign w_finish  = w_last;
`endif

  always_ff @(posedge clock) begin
    if (!reset) begin
      r_state  <= S_IDLE;
      r_a      <= '0;
      r_b      <= '0;
      r_idx    <= '0;
      r_eq_acc <= 1'b0;
      r_gt_acc <= 1'b0;
      r_ready  <= 1'b1;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_eq     <= 1'b0;
      r_gt     <= 1'b0;
      r_lt     <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE, S_DONE: begin
          if (w_accept) begin
            r_state  <= S_RUN;
            r_ready  <= 1'b0;
            r_busy   <= 1'b1;
            r_a      <= opA ^ c_sign_mask;
            r_b      <= opB ^ c_sign_mask;
            r_idx    <= c_idx_first;
            r_eq_acc <= 1'b1;
            r_gt_acc <= 1'b0;
          end else begin
            r_state  <= S_IDLE;
            r_ready  <= 1'b1;
            r_busy   <= 1'b0;
          end
        end
        S_RUN: begin
          r_eq_acc <= w_eq_next;
          r_gt_acc <= w_gt_next;
          r_a      <= r_a << 2;
          r_b      <= r_b << 2;
          r_idx    <= r_idx - 1'b1;
          if (w_finish) begin
            r_state <= S_DONE;
            r_ready <= 1'b1;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            r_eq    <= w_eq_next;
            r_gt    <= w_gt_next;
            r_lt    <= !w_eq_next && !w_gt_next;
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_ready <= 1'b1;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign ready = r_ready;
  assign busy  = r_busy;
  assign done  = r_done;
  assign eq    = r_eq;
  assign gt    = r_gt;
  assign lt    = r_lt;

endmodule

`default_nettype wire

// File: tb/tb_multicycle_compare.sv
// ============================================================================
// Module   : tb_multicycle_compare
// Purpose  : Scoreboard bench for multicycle_compare, signed and unsigned
//            instances driven with the same directed operand pairs.
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_multicycle_compare;

  localparam int W = 32;
  localparam int N = W / 2;

  typedef struct {
    logic [2:0] flags;  // {eq, gt, lt}
    int         cyc;
  } exp_t;

  logic        clk   = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [31:0] opA   = '0;
  logic [31:0] opB   = '0;

  logic s_ready, s_busy, s_done, s_eq, s_gt, s_lt;
  logic u_ready, u_busy, u_done, u_eq, u_gt, u_lt;

  exp_t        qs[$];
  exp_t        qu[$];
  int          cyc     = 0;
  int          n_vec   = 0;
  int          n_err   = 0;
  bit          end_req = 1'b0;
  int          drain   = 0;
  bit          pend[2];
  bit          hold_ok[2];
  logic [2:0]  held[2];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  multicycle_compare #(.WIDTH(W), .SIGNED(1)) u_dut_s (
    .clock(clk), .reset(rst_n), .start(start), .opA(opA), .opB(opB),
    .ready(s_ready), .busy(s_busy), .done(s_done),
    .eq(s_eq), .gt(s_gt), .lt(s_lt)
  );

  multicycle_compare #(.WIDTH(W), .SIGNED(0)) u_dut_u (
    .clock(clk), .reset(rst_n), .start(start), .opA(opA), .opB(opB),
    .ready(u_ready), .busy(u_busy), .done(u_done),
    .eq(u_eq), .gt(u_gt), .lt(u_lt)
  );

  // Cycles from accept to done: first differing digit with early exit, else N+1.
  function automatic int exp_lat(input logic [31:0] a, input logic [31:0] b, input bit sgn);
    logic [31:0] x;
    logic [31:0] y;
    int          d;
    x = a;
    y = b;
    if (sgn) begin
      x[31] = ~x[31];
      y[31] = ~y[31];
    end
    d = N;
    for (int i = 0; i < N; i++) begin
      if (x[31-2*i -: 2] != y[31-2*i -: 2]) begin
        d = i + 1;
        break;
      end
    end
`ifdef CMP_EARLY_EXIT_EN
    return d + 1;
`else
    return (d > 0) ? N + 1 : 0;
`endif
  endfunction

  task automatic chk(input string tag, input string nm,
                     input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s_%s: actual=%0h expected=%0h (cycle %0d)", tag, nm, act, exp, cyc);
    end
  endtask

  task automatic mon(input int d, input logic rdy, input logic bsy,
                     input logic dn, input logic [2:0] fl);
    exp_t  e;
    string tag;
    tag = (d == 0) ? "signed" : "unsigned";
    if (pend[d]) begin
      chk(tag, "reset_state", {26'b0, rdy, bsy, dn, fl}, 32'b100000);
      held[d]    = 3'b000;
      hold_ok[d] = 1'b1;
      pend[d]    = 1'b0;
    end else if (hold_ok[d]) begin
      chk(tag, "ready_vs_busy", {31'b0, rdy}, {31'b0, ~bsy});
      if (dn) begin
        if ((d == 0 && qs.size() == 0) || (d == 1 && qu.size() == 0)) begin
          chk(tag, "unexpected_done", {31'b0, dn}, 32'd0);
        end else begin
          if (d == 0) e = qs.pop_front();
          else        e = qu.pop_front();
          chk(tag, "flags", {29'b0, fl}, {29'b0, e.flags});
          chk(tag, "done_cycle", cyc, e.cyc);
          held[d] = fl;
        end
      end else begin
        chk(tag, "held_flags", {29'b0, fl}, {29'b0, held[d]});
      end
    end
    if (!rst_n) begin
      pend[d] = 1'b1;
      if (d == 0) qs.delete();
      else        qu.delete();
    end
  endtask

  always @(negedge clk) begin
    mon(0, s_ready, s_busy, s_done, {s_eq, s_gt, s_lt});
    mon(1, u_ready, u_busy, u_done, {u_eq, u_gt, u_lt});
    if (end_req) begin
      if ((qs.size() == 0 && qu.size() == 0) || drain >= 300) begin
        chk("signed", "pending_results", qs.size(), 32'd0);
        chk("unsigned", "pending_results", qu.size(), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
      end
      drain++;
    end
  end

  // Waits for both instances to be ready, then raises start and books results.
  task automatic issue(input logic [31:0] a, input logic [31:0] b,
                       input logic [2:0] fs, input logic [2:0] fu, input bit keep);
    exp_t e;
    @(posedge clk); #1;
    opA = a;
    opB = b;
    for (int t = 0; t <= 300; t++) begin
      if (t == 300) begin
        $display("FAIL issue_timeout: ready low for 300 cycles (a=%0h b=%0h)", a, b);
        $fatal(1, "bench stalled");
      end
      if (s_ready && u_ready) break;
      @(posedge clk); #1;
    end
    start   = 1'b1;
    e.flags = fs;
    e.cyc   = cyc + exp_lat(a, b, 1'b1);
    qs.push_back(e);
    e.flags = fu;
    e.cyc   = cyc + exp_lat(a, b, 1'b0);
    qu.push_back(e);
    if (!keep) begin
      @(posedge clk); #1;
      start = 1'b0;
    end
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    issue(32'h1234_5678, 32'h1234_5678, 3'b100, 3'b100, 1'b0);
    issue(32'd5,         32'd3,         3'b010, 3'b010, 1'b0);
    issue(32'd3,         32'd5,         3'b001, 3'b001, 1'b0);
    issue(32'hFFFF_FFFF, 32'd1,         3'b001, 3'b010, 1'b0);
    issue(32'h8000_0000, 32'd0,         3'b001, 3'b010, 1'b0);
    issue(32'd0,         32'hFFFF_FFFF, 3'b010, 3'b001, 1'b0);
    issue(32'h7FFF_FFFF, 32'h8000_0000, 3'b010, 3'b001, 1'b0);

    // start stays high: second request lands in the first done cycle
    issue(32'd7, 32'd7, 3'b100, 3'b100, 1'b1);
    issue(32'd2, 32'd9, 3'b001, 3'b001, 1'b0);

    // abort in RUN cycle 5; its booked result is discarded on reset
    issue(32'd9, 32'd4, 3'b010, 3'b010, 1'b0);
    repeat (4) @(posedge clk);
    #1 rst_n = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b1;

    issue(32'hA5A5_A5A5, 32'hA5A5_A5A4, 3'b010, 3'b010, 1'b0);
    issue(32'h0000_0001, 32'hFFFF_FFFE, 3'b010, 3'b001, 1'b0);

    end_req = 1'b1;
  end

endmodule

`default_nettype wire
